// File: rtl/riscv_mmio_pkg.sv
// Shared definitions for the RISC-V MMIO load path: device map and read-mux FSM encoding.
package riscv_mmio_pkg;

  localparam int DEV_MEM       = 0;
  localparam int DEV_UART_TX   = 1;
  localparam int DEV_UART_RX   = 2;
  localparam int DEV_UART_TX_O = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mmio_state_t;

  // A wait counter must exist even when memory needs no extra cycles.
  function automatic int wait_cnt_width(input int mem_wait);
    return (mem_wait > 0) ? $clog2(mem_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/mmio_rx_flags.sv
// UART RX pending/overrun flags: set by rx_new, cleared when an RX-data read completes.
module mmio_rx_flags (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_new,
  input  logic clr,
  output logic rx_pending,
  output logic rx_overrun
);

  logic pending_reg, pending_next;
  logic overrun_reg, overrun_next;

  // A byte arriving alongside the completing read is new data, so pending survives.
  always_comb begin
    pending_next = pending_reg;
    overrun_next = overrun_reg;
    if (rx_new)
      pending_next = 1'b1;
    else if (clr)
      pending_next = 1'b0;
    if (rx_new && pending_reg && !clr)
      overrun_next = 1'b1;
    else if (clr)
      overrun_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
    end
  end

  assign rx_pending = pending_reg;
  assign rx_overrun = overrun_reg;

endmodule

// File: rtl/mmio_read_mux.sv
// Registered MMIO read-back mux: selects memory or a peripheral register, inserts
// memory wait states and returns data with a one-cycle valid strobe.
module mmio_read_mux
  import riscv_mmio_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_DEV    = 4,
  parameter  int MEM_WAIT   = 1,
  parameter  int RX_DEV     = DEV_UART_RX,
  localparam int SEL_W      = $clog2(NUM_DEV)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_req,
  input  logic [SEL_W-1:0]              sel,
  input  logic [NUM_DEV*DATA_WIDTH-1:0] dev_data,
  input  logic                          rx_new,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic                          rd_err,
  output logic                          busy,
  output logic                          rx_pending,
  output logic                          rx_overrun
);

  localparam int                CNT_W       = wait_cnt_width(MEM_WAIT);
  localparam int                WAIT_INIT   = (MEM_WAIT > 0) ? MEM_WAIT - 1 : 0;
  localparam logic [CNT_W-1:0]  WAIT_INIT_C = WAIT_INIT[CNT_W-1:0];
  localparam logic [SEL_W:0]    NUM_DEV_C   = NUM_DEV[SEL_W:0];
  localparam logic [SEL_W-1:0]  RX_SEL      = RX_DEV[SEL_W-1:0];

  mmio_state_t             state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [SEL_W-1:0]        sel_q_reg, sel_q_next;
  logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
  logic                    rd_valid_reg, rd_valid_next;
  logic                    rd_err_reg, rd_err_next;
  logic                    capture;
  logic                    cap_err;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [DATA_WIDTH-1:0]   dev_term [NUM_DEV];
  logic                    clr;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_q_next = sel_q_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rd_req) begin
          sel_q_next = sel;
          if (sel == '0 && MEM_WAIT > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_INIT_C;
          end else begin
            state_next = ST_RESP;
            capture    = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = ST_RESP;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // sel_q_next is the live sel on a zero-wait capture and the latched one otherwise.
  generate
    for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
      assign dev_term[gi] = dev_data[gi*DATA_WIDTH +: DATA_WIDTH]
                            & {DATA_WIDTH{sel_q_next == SEL_W'(gi)}};
    end
  endgenerate

  always_comb begin
    cap_data = '0;
    for (int k = 0; k < NUM_DEV; k++)
      cap_data = cap_data | dev_term[k];
  end

  assign cap_err       = ({1'b0, sel_q_next} >= NUM_DEV_C);
  assign rd_valid_next = capture;
  assign rd_err_next   = capture ? cap_err : rd_err_reg;
  assign rd_data_next  = capture ? (cap_err ? '0 : cap_data) : rd_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      sel_q_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      sel_q_reg    <= sel_q_next;
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
      rd_err_reg   <= rd_err_next;
    end
  end

  assign clr = rd_valid_reg & ~rd_err_reg & (sel_q_reg == RX_SEL);

  mmio_rx_flags u_rx_flags (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_new     (rx_new),
    .clr        (clr),
    .rx_pending (rx_pending),
    .rx_overrun (rx_overrun)
  );

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_err   = rd_err_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mmio_read_mux.sv
// Bench for mmio_read_mux (3 sources, one memory wait state): directed scenarios then
// random traffic, all checked against a cycle-scheduled transaction model.
module tb_mmio_read_mux;

  localparam int DW  = 32;
  localparam int ND  = 3;
  localparam int MW  = 1;
  localparam int RXD = 2;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_req = 1'b0;
  logic [SW-1:0]     sel = '0;
  logic [ND*DW-1:0]  dev_data = '0;
  logic              rx_new = 1'b0;
  logic [DW-1:0]     rd_data;
  logic              rd_valid, rd_err, busy, rx_pending, rx_overrun;

  always #5 clk = ~clk;

  mmio_read_mux #(
    .DATA_WIDTH (DW),
    .NUM_DEV    (ND),
    .MEM_WAIT   (MW),
    .RX_DEV     (RXD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req     (rd_req),
    .sel        (sel),
    .dev_data   (dev_data),
    .rx_new     (rx_new),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_err     (rd_err),
    .busy       (busy),
    .rx_pending (rx_pending),
    .rx_overrun (rx_overrun)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a request accepted in cycle t is captured at the end of cycle t+L
  // and is visible (rd_valid) in cycle t+1+L; busy spans t+1 .. t+1+L.
  int          t = 0;
  int          busy_from = -1, busy_until = -1, cap_cycle = -1, resp_cycle = -1;
  logic [DW-1:0] m_data = '0;
  bit          m_err = 1'b0;
  int          m_sel = 0;
  bit          m_pend = 1'b0, m_ovr = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_clear();
    busy_from = -1; busy_until = -1; cap_cycle = -1; resp_cycle = -1;
    m_data = '0; m_err = 1'b0; m_sel = 0; m_pend = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive this cycle's inputs, advance model.
  task automatic step(input bit req, input int s, input bit rxn, input bit rnd);
    bit exp_valid, exp_busy, clr;
    int lat;
    @(posedge clk);
    #1;
    t++;
    exp_valid = (t == resp_cycle);
    exp_busy  = (t >= busy_from) && (t <= busy_until);
    check_val("rd_valid",   32'(rd_valid),   32'(exp_valid));
    check_val("busy",       32'(busy),       32'(exp_busy));
    check_val("rd_data",    rd_data,         m_data);
    check_val("rx_pending", 32'(rx_pending), 32'(m_pend));
    check_val("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
    if (exp_valid)
      check_val("rd_err", 32'(rd_err), 32'(m_err));
    if (rd_valid)
      $display("read cycle=%0d sel=%0d data=%h err=%0b pend=%0b ovr=%0b",
               t, m_sel, rd_data, rd_err, rx_pending, rx_overrun);

    if (rnd) dev_data = {$urandom, $urandom, $urandom};
    rd_req = req;
    sel    = SW'(s);
    rx_new = rxn;

    clr = exp_valid && !m_err && (m_sel == RXD);
    if (req && !exp_busy) begin
      m_sel      = s;
      lat        = (s == 0) ? MW : 0;
      cap_cycle  = t + lat;
      resp_cycle = t + 1 + lat;
      busy_from  = t + 1;
      busy_until = t + 1 + lat;
    end
    if (t == cap_cycle) begin
      m_err  = (m_sel >= ND);
      m_data = m_err ? '0 : dev_data[m_sel*DW +: DW];
    end
    if (rxn && m_pend && !clr) m_ovr = 1'b1;
    else if (clr)              m_ovr = 1'b0;
    if (rxn)      m_pend = 1'b1;
    else if (clr) m_pend = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_data"},  rd_data,           32'h0);
    check_val({tag, "_valid"}, 32'(rd_valid),     32'h0);
    check_val({tag, "_err"},   32'(rd_err),       32'h0);
    check_val({tag, "_busy"},  32'(busy),         32'h0);
    check_val({tag, "_pend"},  32'(rx_pending),   32'h0);
    check_val({tag, "_ovr"},   32'(rx_overrun),   32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 rst_n = 1'b1;

    dev_data = {32'h0000_0055, 32'h0000_0041, 32'hDEAD_BEEF};

    // Memory read with one wait state.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("mem_busy_t1", 32'(busy), 32'h1);
    step(0, 0, 0, 0);
    check_val("mem_valid_t2", 32'(rd_valid), 32'h1);
    check_val("mem_data_t2", rd_data, 32'hDEAD_BEEF);
    step(0, 0, 0, 0);

    // Zero-wait peripheral read; a request during RESP is dropped.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check_val("tx_valid_t1", 32'(rd_valid), 32'h1);
    check_val("tx_data_t1", rd_data, 32'h0000_0041);
    step(0, 0, 0, 0);
    check_val("tx_no_second", 32'(rd_valid), 32'h0);

    // Out-of-range select.
    step(1, 3, 0, 0);
    step(0, 0, 0, 0);
    check_val("oor_err", 32'(rd_err), 32'h1);
    check_val("oor_data", rd_data, 32'h0);

    // Pending, overrun, then clear by reading RX.
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check_val("pend_set", 32'(rx_pending), 32'h1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check_val("ovr_set", 32'(rx_overrun), 32'h1);
    step(1, 2, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("pend_clr", 32'(rx_pending), 32'h0);
    check_val("ovr_clr", 32'(rx_overrun), 32'h0);

    // New byte coincident with the completing RX read.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(1, 2, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check_val("coinc_pend", 32'(rx_pending), 32'h1);
    check_val("coinc_ovr", 32'(rx_overrun), 32'h0);

    // Reset in the middle of a memory wait.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    #2;
    rst_n  = 1'b0;
    rd_req = 1'b0;
    rx_new = 1'b0;
    #1;
    check_all_zero("midrst");
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    check_val("post_rst_valid", 32'(rd_valid), 32'h1);
    check_val("post_rst_data", rd_data, 32'h0000_0041);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0), 1'b1);
    repeat (4) step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
